fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, program-counter and instruction-memory address width in words.
REQ-002 The block SHALL have parameter INST_WIDTH, default 32, instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 imem_pc  output  ADDR_WIDTH  word address to instruction memory.
REQ-007 imem_inst  input  INST_WIDTH  instruction memory read data, combinational from imem_pc, valid in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump/exception redirect request.
REQ-009 redirect_pc  input  ADDR_WIDTH  redirect target word address.
REQ-010 halt_req  input  1  stop fetching.
REQ-011 dec_valid  output  1  decode-side entry available.
REQ-012 dec_ready  input  1  decode accepts the head entry.
REQ-013 dec_inst  output  INST_WIDTH  head instruction.
REQ-014 dec_pc  output  ADDR_WIDTH  address of the head instruction.
REQ-015 halted  output  1  high while in HALTED.
REQ-016 fetch_count  output  16  number of words pushed since reset.

Function
REQ-017 imem_pc SHALL equal the internal pc register at all times, so memory data always corresponds to pc.
REQ-018 The FSM SHALL have states BOOT, RUN and HALTED; BOOT SHALL go to RUN unconditionally after one cycle and SHALL perform no fetch.
REQ-019 A 2-entry FIFO SHALL hold {pc, instruction} pairs; dec_valid = (count != 0); dec_inst/dec_pc SHALL show the head entry.
REQ-020 Pop SHALL occur on a rising edge when dec_valid and dec_ready are both high.
REQ-021 Fetch SHALL occur in RUN when count, sampled before that edge's pop, is below 2 and redirect_valid and halt_req are low: push {pc, imem_inst}; pc <= pc + 1.
REQ-022 pc increment SHALL wrap modulo 2^ADDR_WIDTH; all-ones SHALL be followed by 0.
REQ-023 Simultaneous push and pop at count 1 SHALL leave count at 1, with the new entry becoming head.
REQ-024 redirect_valid SHALL have highest priority: FIFO emptied, pc <= redirect_pc, no push or pop counted, and next state RUN from any state, including HALTED and BOOT.
REQ-025 halt_req without redirect in RUN SHALL move to HALTED without fetching; FIFO contents SHALL remain and drain normally.
REQ-026 HALTED SHALL be left only via redirect_valid; halted SHALL be high exactly in HALTED.
REQ-027 fetch_count SHALL increment by 1 on each push and wrap at 2^16.
REQ-028 dec_inst/dec_pc SHALL be held stable while dec_valid is high and dec_ready is low.

Reset
REQ-029 While reset_n is low, asynchronously: pc = RESET_PC, FIFO count 0, state BOOT, dec_valid 0, halted 0, fetch_count 0.
REQ-030 Reset assertion mid-operation SHALL discard all FIFO entries and any pending redirect or halt.

Verification
REQ-031 Reset release, dec_ready=1, memory word i = 0x1000+i -> dec_valid first high at the second edge after release, then dec_pc 0,1,2... with dec_inst 0x1000,0x1001,... one per cycle.
REQ-032 dec_ready=0 for 5 cycles -> exactly 2 entries buffered (pc 0,1), imem_pc holds 2, fetch_count=2; raising dec_ready delivers 0,1,2 in order with no gap or duplicate.
REQ-033 redirect_valid with redirect_pc=0x40 while FIFO holds 2 entries -> next cycle dec_valid=0, imem_pc=0x40; following entries carry dec_pc 0x40,0x41.
REQ-034 halt_req pulse -> halted=1, imem_pc frozen, buffered entries drain; redirect to 0x10 -> halted=0 and fetching resumes at 0x10.
REQ-035 Redirect to 0xFFFF (ADDR_WIDTH=16) -> dec_pc sequence 0xFFFF, 0x0000, 0x0001.
REQ-036 reset_n pulsed low mid-stream with 2 entries buffered -> dec_valid, fetch_count and halted immediately 0 and imem_pc=RESET_PC before the next clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: BOOT/RUN/HALTED sequencer driving a word-addressed
// instruction memory and a 2-entry {pc, instruction} queue toward decode.
module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] imem_pc,
    input  logic [INST_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  halted,
    output logic [15:0]           fetch_count
);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] fifo_pc   [2];
    logic [INST_WIDTH-1:0] fifo_inst [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count;
    logic                  push, pop;

    // Redirect overrides everything: no push, no pop, and RUN from any state.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (redirect_valid) begin
            state_next = RUN;
        end else begin
            unique case (state)
                BOOT:   state_next = RUN;
                RUN: begin
                    if (halt_req) state_next = HALTED;
                    else          push       = (count < 2'd2);
                end
                HALTED: state_next = HALTED;
                default: state_next = BOOT;
            endcase
        end
        pop = dec_valid && dec_ready && !redirect_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            count       <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc     <= redirect_pc;
                count  <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    pc          <= pc + 1'b1;
                    wr_ptr      <= ~wr_ptr;
                    fetch_count <= fetch_count + 16'd1;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                unique case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pc;
            fifo_inst[wr_ptr] <= imem_inst;
        end
    end

    assign imem_pc   = pc;
    assign dec_valid = (count != 2'd0);
    assign dec_pc    = fifo_pc[rd_ptr];
    assign dec_inst  = fifo_inst[rd_ptr];
    assign halted    = (state == HALTED);

endmodule
